// File: rtl/cpu_pkg.sv
// Shared datapath width and ALU opcode constants for the execution unit and control unit.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_INC  = 4'b0010;
    localparam logic [3:0] ALU_DEC  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SHR  = 4'b0110;
    localparam logic [3:0] ALU_SHL  = 4'b0111;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction
endpackage

// File: rtl/regfile8x16.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
module regfile8x16
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] w_adr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [REG_AW-1:0] r_adr,
    input  logic [REG_AW-1:0] s_adr,
    output logic [DATA_W-1:0] r_out,
    output logic [DATA_W-1:0] s_out
);
    logic [(1<<REG_AW)-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[w_adr] = w_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
    assign r_out = regs_q[r_adr];
    assign s_out = regs_q[s_adr];
endmodule

// File: rtl/cpu_exec_unit.sv
// Execution datapath: register file, ALU with flags, PC, IR and memory address mux.
module cpu_exec_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        W_Adr,
    input  logic [2:0]        R_Adr,
    input  logic [2:0]        S_Adr,
    input  logic              adr_sel,
    input  logic              s_sel,
    input  logic              pc_ld,
    input  logic              pc_inc,
    input  logic              pc_sel,
    input  logic              ir_ld,
    input  logic              rw_en,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] Address,
    output logic [DATA_W-1:0] D_out,
    output logic [DATA_W-1:0] IR,
    output logic              N,
    output logic              Z,
    output logic              C
);
    logic [DATA_W-1:0] r_out, s_out, w_data, alu_out;
    logic              alu_c;
    logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d;

    regfile8x16 u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rw_en),
        .w_adr  (W_Adr),
        .w_data (w_data),
        .r_adr  (R_Adr),
        .s_adr  (S_Adr),
        .r_out  (r_out),
        .s_out  (s_out)
    );

    // Carry column doubles as borrow for subtract/decrement (17-bit wrap).
    always_comb begin
        alu_out = s_out;
        alu_c   = 1'b0;
        case (alu_op)
            ALU_INC: {alu_c, alu_out} = {1'b0, s_out} + 17'd1;
            ALU_DEC: {alu_c, alu_out} = {1'b0, s_out} - 17'd1;
            ALU_ADD: {alu_c, alu_out} = {1'b0, r_out} + {1'b0, s_out};
            ALU_SUB: {alu_c, alu_out} = {1'b0, r_out} - {1'b0, s_out};
            ALU_SHR: begin
                alu_out = {1'b0, s_out[DATA_W-1:1]};
                alu_c   = s_out[0];
            end
            ALU_SHL: begin
                alu_out = {s_out[DATA_W-2:0], 1'b0};
                alu_c   = s_out[DATA_W-1];
            end
            default: begin
                alu_out = s_out;
                alu_c   = 1'b0;
            end
        endcase
    end

    assign N = alu_out[DATA_W-1];
    assign Z = (alu_out == '0);
    assign C = alu_c;

    assign w_data = s_sel ? D_in : alu_out;

    always_comb begin
        pc_d = pc_q;
        if (pc_ld)       pc_d = pc_sel ? s_out : pc_q + sext8(ir_q[7:0]);
        else if (pc_inc) pc_d = pc_q + 16'd1;
    end

    always_comb begin
        ir_d = ir_q;
        if (ir_ld) ir_d = D_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign Address = adr_sel ? s_out : pc_q;
    assign D_out   = r_out;
    assign IR      = ir_q;
endmodule
